// File: rtl/pong_pkg.sv
// Shared constants for the pong board: FSM encodings and ADC/pot widths.
package pong_pkg;

    localparam int unsigned ADC_FRAME_BITS = 16;
    localparam int unsigned ADC_RES        = 12;
    localparam int unsigned POT_W          = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CONV   = 2'd1;
    localparam logic [1:0] ST_QUIET  = 2'd2;
    localparam logic [1:0] ST_UPDATE = 2'd3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous header input.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pot_adc_reader.sv
// Dual-channel serial ADC front end: runs AD7476A-style frames, averages
// 2^AVG_LOG2 conversions per channel and publishes 8-bit pot values.
module pot_adc_reader
    import pong_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 16,
    parameter int unsigned QUIET_CYC = 50,
    parameter int unsigned AVG_LOG2  = 3
) (
    input  logic             board_clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             ad_sdata0,
    input  logic             ad_sdata1,
    output logic             ad_cs_n,
    output logic             ad_sclk,
    output logic [POT_W-1:0] pot0,
    output logic [POT_W-1:0] pot1,
    output logic             pot_valid
);

    localparam int unsigned DIV_W  = $clog2(CLK_DIV);
    localparam int unsigned QW     = $clog2(QUIET_CYC + 1);
    localparam int unsigned HALF_W = $clog2(2 * ADC_FRAME_BITS);
    localparam int unsigned ACC_W  = ADC_RES + AVG_LOG2;
    localparam int unsigned CNT_W  = AVG_LOG2 + 1;

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [QW-1:0]     QUIET_LAST = QW'(QUIET_CYC - 1);
    localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(2 * ADC_FRAME_BITS - 1);
    localparam logic [CNT_W-1:0]  N_AVG      = CNT_W'(2 ** AVG_LOG2);

    logic sd0, sd1;

    sync_2ff u_sync0 (.clk(board_clk), .reset(reset), .d(ad_sdata0), .q(sd0));
    sync_2ff u_sync1 (.clk(board_clk), .reset(reset), .d(ad_sdata1), .q(sd1));

    logic [1:0]         state,     state_nxt;
    logic [DIV_W-1:0]   div_cnt,   div_nxt;
    logic [HALF_W-1:0]  half_cnt,  half_nxt;
    logic [QW-1:0]      quiet_cnt, quiet_nxt;
    logic [ADC_RES-1:0] sr0,       sr0_nxt;
    logic [ADC_RES-1:0] sr1,       sr1_nxt;
    logic [ACC_W-1:0]   acc0,      acc0_nxt;
    logic [ACC_W-1:0]   acc1,      acc1_nxt;
    logic [CNT_W-1:0]   sample_cnt, cnt_nxt;
    logic               cs_n_nxt, sclk_nxt, valid_nxt;
    logic [POT_W-1:0]   pot0_nxt, pot1_nxt;
    logic               update_due;

    // State and datapath registers.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            div_cnt    <= '0;
            half_cnt   <= '0;
            quiet_cnt  <= '0;
            sr0        <= '0;
            sr1        <= '0;
            acc0       <= '0;
            acc1       <= '0;
            sample_cnt <= '0;
            ad_cs_n    <= 1'b1;
            ad_sclk    <= 1'b1;
            pot0       <= '0;
            pot1       <= '0;
            pot_valid  <= 1'b0;
        end else begin
            state      <= state_nxt;
            div_cnt    <= div_nxt;
            half_cnt   <= half_nxt;
            quiet_cnt  <= quiet_nxt;
            sr0        <= sr0_nxt;
            sr1        <= sr1_nxt;
            acc0       <= acc0_nxt;
            acc1       <= acc1_nxt;
            sample_cnt <= cnt_nxt;
            ad_cs_n    <= cs_n_nxt;
            ad_sclk    <= sclk_nxt;
            pot0       <= pot0_nxt;
            pot1       <= pot1_nxt;
            pot_valid  <= valid_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt  = state;
        div_nxt    = div_cnt;
        half_nxt   = half_cnt;
        quiet_nxt  = quiet_cnt;
        sr0_nxt    = sr0;
        sr1_nxt    = sr1;
        acc0_nxt   = acc0;
        acc1_nxt   = acc1;
        cnt_nxt    = sample_cnt;
        cs_n_nxt   = ad_cs_n;
        sclk_nxt   = ad_sclk;
        pot0_nxt   = pot0;
        pot1_nxt   = pot1;
        valid_nxt  = 1'b0;
        update_due = 1'b0;

        case (state)
            ST_IDLE: begin
                acc0_nxt = '0;
                acc1_nxt = '0;
                cnt_nxt  = '0;
                div_nxt  = '0;
                half_nxt = '0;
                cs_n_nxt = 1'b1;
                sclk_nxt = 1'b1;
                if (enable) begin
                    state_nxt = ST_CONV;
                    cs_n_nxt  = 1'b0;
                end
            end

            ST_CONV: begin
                if (div_cnt == DIV_LAST) begin
                    div_nxt  = '0;
                    sclk_nxt = ~ad_sclk;
                    half_nxt = half_cnt + HALF_W'(1);
                    // Capture on the 0->1 transition; the leading zeros fall off the top.
                    if (!ad_sclk) begin
                        sr0_nxt = {sr0[ADC_RES-2:0], sd0};
                        sr1_nxt = {sr1[ADC_RES-2:0], sd1};
                    end
                    if (half_cnt == HALF_LAST) begin
                        half_nxt  = '0;
                        quiet_nxt = '0;
                        cs_n_nxt  = 1'b1;
                        state_nxt = ST_QUIET;
                    end
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end

            ST_QUIET: begin
                update_due = (sample_cnt == N_AVG);
                if (quiet_cnt == '0) begin
                    acc0_nxt   = acc0 + ACC_W'(sr0);
                    acc1_nxt   = acc1 + ACC_W'(sr1);
                    cnt_nxt    = sample_cnt + CNT_W'(1);
                    update_due = (cnt_nxt == N_AVG);
                end
                if (quiet_cnt == QUIET_LAST) begin
                    if (update_due) begin
                        state_nxt = ST_UPDATE;
                        pot0_nxt  = acc0_nxt[ACC_W-1 -: POT_W];
                        pot1_nxt  = acc1_nxt[ACC_W-1 -: POT_W];
                        valid_nxt = 1'b1;
                    end else if (enable) begin
                        state_nxt = ST_CONV;
                        cs_n_nxt  = 1'b0;
                        div_nxt   = '0;
                        half_nxt  = '0;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    quiet_nxt = quiet_cnt + QW'(1);
                end
            end

            ST_UPDATE: begin
                acc0_nxt = '0;
                acc1_nxt = '0;
                cnt_nxt  = '0;
                div_nxt  = '0;
                half_nxt = '0;
                if (enable) begin
                    state_nxt = ST_CONV;
                    cs_n_nxt  = 1'b0;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                cs_n_nxt  = 1'b1;
                sclk_nxt  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_pot_adc_reader.sv
// Directed bench for pot_adc_reader with a behavioural dual-channel ADC model.
module tb_pot_adc_reader;

    logic       board_clk = 1'b0;
    logic       reset     = 1'b0;
    logic       enable    = 1'b0;
    logic       ad_sdata0 = 1'b0;
    logic       ad_sdata1 = 1'b0;
    logic       ad_cs_n;
    logic       ad_sclk;
    logic [7:0] pot0;
    logic [7:0] pot1;
    logic       pot_valid;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 board_clk = ~board_clk;

    pot_adc_reader dut (
        .board_clk (board_clk),
        .reset     (reset),
        .enable    (enable),
        .ad_sdata0 (ad_sdata0),
        .ad_sdata1 (ad_sdata1),
        .ad_cs_n   (ad_cs_n),
        .ad_sclk   (ad_sclk),
        .pot0      (pot0),
        .pot1      (pot1),
        .pot_valid (pot_valid)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ADC model: word = {4'b0, result}, next bit driven after each SCLK fall.
    int          mode        = 0;
    bit          toggle_data = 1'b0;
    int          frame_no    = 0;
    int          bit_idx     = 15;
    logic [15:0] w0          = '0;
    logic [15:0] w1          = '0;
    logic        m_prev_cs   = 1'b1;
    logic        m_prev_sclk = 1'b1;

    function automatic logic [11:0] ch0_val(input int m, input int f);
        if (m == 0) return 12'hABC;
        return (f % 2 == 1) ? 12'hFF0 : 12'h000;
    endfunction

    function automatic logic [11:0] ch1_val(input int m);
        return (m == 0) ? 12'h123 : 12'hFFF;
    endfunction

    always @(negedge board_clk) begin
        if (toggle_data) begin
            ad_sdata0 = ~ad_sdata0;
            ad_sdata1 = ~ad_sdata1;
        end else begin
            if (m_prev_cs && !ad_cs_n) begin
                frame_no++;
                w0      = {4'h0, ch0_val(mode, frame_no)};
                w1      = {4'h0, ch1_val(mode)};
                bit_idx = 15;
            end
            if (m_prev_sclk && !ad_sclk && !ad_cs_n && bit_idx >= 0) begin
                ad_sdata0 = w0[bit_idx];
                ad_sdata1 = w1[bit_idx];
                bit_idx--;
            end
        end
        m_prev_cs   = ad_cs_n;
        m_prev_sclk = ad_sclk;
    end

    // Frame timing monitor.
    logic mon_prev_cs   = 1'b1;
    logic mon_prev_sclk = 1'b1;
    int   low_cnt  = 0;
    int   high_cnt = 100;
    int   rise_cnt = 0;
    bit   sclk_bad = 1'b0;

    always @(negedge board_clk) begin
        if (reset) begin
            mon_prev_cs   = 1'b1;
            mon_prev_sclk = 1'b1;
            low_cnt       = 0;
            high_cnt      = 100;
            rise_cnt      = 0;
            sclk_bad      = 1'b0;
        end else begin
            if (ad_sclk && !mon_prev_sclk) rise_cnt++;
            if (!ad_cs_n) begin
                if (mon_prev_cs) begin
                    check_eq("quiet_gap_ge50", 32'(high_cnt >= 50), 32'd1);
                    check_eq("sclk_high_while_cs_high", 32'(sclk_bad), 32'd0);
                    sclk_bad = 1'b0;
                end
                low_cnt++;
            end else begin
                if (!mon_prev_cs) begin
                    check_eq("cs_low_cycles", 32'(low_cnt), 32'd512);
                    check_eq("sclk_rises_per_frame", 32'(rise_cnt), 32'd16);
                    high_cnt = 0;
                end
                low_cnt  = 0;
                rise_cnt = 0;
                high_cnt++;
                if (!ad_sclk) sclk_bad = 1'b1;
            end
            mon_prev_cs   = ad_cs_n;
            mon_prev_sclk = ad_sclk;
        end
    end

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge board_clk);
            n++;
        end while (!pot_valid && n < 6000);
    endtask

    int  lat;
    int  pulses;
    int  rises;
    int  guard;
    logic prev_sclk;

    initial begin
        // Reset with enable high and data lines toggling.
        enable      = 1'b1;
        toggle_data = 1'b1;
        #2 reset = 1'b1;
        repeat (6) begin
            @(negedge board_clk);
            check_eq("reset_outputs", {13'd0, ad_cs_n, ad_sclk, pot_valid, pot0, pot1},
                     {13'd0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00});
        end
        toggle_data = 1'b0;
        ad_sdata0   = 1'b0;
        ad_sdata1   = 1'b0;
        reset       = 1'b0;

        // Constant ABC / 123, continuous enable.
        wait_valid(lat);
        check_eq("first_valid_latency", 32'(lat), 32'd4497);
        check_eq("pot0_abc", 32'(pot0), 32'hAB);
        check_eq("pot1_123", 32'(pot1), 32'h12);
        @(negedge board_clk);
        check_eq("valid_one_cycle", 32'(pot_valid), 32'd0);
        wait_valid(lat);
        check_eq("valid_period_1", 32'(lat + 1), 32'd4497);
        wait_valid(lat);
        check_eq("valid_period_2", 32'(lat), 32'd4497);
        check_eq("pot_steady", {16'd0, pot0, pot1}, 32'hAB12);

        // Disable straight after the pulse: IDLE, values held.
        enable = 1'b0;
        repeat (20) @(negedge board_clk);
        check_eq("idle_cs_sclk", {30'd0, ad_cs_n, ad_sclk}, 32'd3);
        check_eq("idle_hold_pots", {16'd0, pot0, pot1}, 32'hAB12);

        // Alternating 000/FF0 on ch0, full scale on ch1.
        mode   = 1;
        enable = 1'b1;
        wait_valid(lat);
        check_eq("alt_latency", 32'(lat), 32'd4497);
        check_eq("pot0_alt", 32'(pot0), 32'h7F);
        check_eq("pot1_full", 32'(pot1), 32'hFF);

        // Drop enable during the third conversion.
        repeat (1325) @(negedge board_clk);
        check_eq("in_third_conv", 32'(ad_cs_n), 32'd0);
        enable = 1'b0;
        pulses = 0;
        repeat (1500) begin
            @(negedge board_clk);
            if (pot_valid) pulses++;
        end
        check_eq("no_valid_after_drop", 32'(pulses), 32'd0);
        check_eq("drop_idle_cs_sclk", {30'd0, ad_cs_n, ad_sclk}, 32'd3);
        check_eq("drop_pots_unchanged", {16'd0, pot0, pot1}, 32'h7FFF);

        // Re-enable: partial average must be gone.
        mode   = 0;
        enable = 1'b1;
        wait_valid(lat);
        check_eq("reenable_latency", 32'(lat), 32'd4497);
        check_eq("reenable_pots", {16'd0, pot0, pot1}, 32'hAB12);

        // Reset during the 10th SCLK period of a frame.
        rises     = 0;
        guard     = 0;
        prev_sclk = ad_sclk;
        do begin
            @(negedge board_clk);
            guard++;
            if (ad_sclk && !prev_sclk && !ad_cs_n) rises++;
            prev_sclk = ad_sclk;
        end while (!(rises == 9 && !ad_sclk) && guard < 2000);
        check_eq("reached_10th_sclk", 32'(rises), 32'd9);
        @(negedge board_clk);
        check_eq("pre_reset_cs_low", 32'(ad_cs_n), 32'd0);
        #2 reset = 1'b1;
        #1;
        check_eq("async_reset_outputs", {13'd0, ad_cs_n, ad_sclk, pot_valid, pot0, pot1},
                 {13'd0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00});
        repeat (3) @(negedge board_clk);
        check_eq("reset_no_valid", 32'(pot_valid), 32'd0);
        reset = 1'b0;
        wait_valid(lat);
        check_eq("post_reset_latency", 32'(lat), 32'd4497);
        check_eq("post_reset_pots", {16'd0, pot0, pot1}, 32'hAB12);

        repeat (5) @(negedge board_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
